stage_fetch: RTL and testbench
==============================

# stage_fetch

N-wide instruction fetch stage of the out-of-order core; sits between instruction memory and decode. Issues 64-bit block loads to the tagged, non-blocking memory interface, keeps a small in-order queue of outstanding and completed block requests, and presents up to `N` program-ordered instructions per cycle to decode. A ROB redirect flushes all fetch state and restarts fetch at the target PC.

## Interface
- Parameters: none local. `N` (fetch width) comes from the shared defines.
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: decode cannot accept; presented instructions are not consumed.
- `mem2proc_transaction_tag` in MEM_TAG (4): tag granted to this cycle's request; 0 means rejected.
- `mem2proc_data` in MEM_BLOCK (64): returned block.
- `mem2proc_data_tag` in MEM_TAG (4): tag of returned data; 0 means none.
- `rob_if_packet` in ROB_IF_PACKET: `squash` (1) and `PC` (ADDR) redirect target.
- `proc2Imem_command` out MEM_COMMAND (2): MEM_NONE or MEM_LOAD.
- `proc2Imem_addr` out ADDR (32): 8-byte-aligned block address; 0 when command is MEM_NONE.
- `if_id_packet` out IF_ID_PACKET [N-1:0]: `inst`, `PC`, `NPC` (= PC+4), and `valid`. Slot 0 is the oldest.

## Operation
- State:
  - `fetch_pc`, the next block to request.
  - Request queue: circular, `FETCH_Q_DEPTH` = 4 entries. Each entry holds `valid`, `tag`, `blk_addr`, `start_word` (0/1), `data_valid`, and `data`.
  - `head_word`, the next word to emit from the head entry.
- Request:
  - The request condition is: queue not full, no squash this cycle, and not reset.
  - When it holds, drive MEM_LOAD to `{fetch_pc[31:3],3'b0}`.
  - If the granted tag ≠ 0: push an entry with `start_word = fetch_pc[2]` and set `fetch_pc` to the next aligned block (+8).
  - If the granted tag = 0: push nothing; retry the same address next cycle.
- Response:
  - When `data_tag` ≠ 0, the valid entry with a matching tag with `data_valid` = 0 captures the data and sets `data_valid`.
  - If no entry matches (a request killed by a squash), the response is dropped.
  - Tags are unique among outstanding loads, so at most one entry matches.
- Output (combinational from queue state):
  - Walk from the head entry, starting at its `head_word`.
  - Word 0 is `data[31:0]` at `blk_addr`; word 1 is `data[63:32]` at `blk_addr+4`.
  - Fill slots 0..N-1 with consecutive instructions. Stop at the first entry with `data_valid` = 0 or at an empty queue.
  - Unfilled slots have `valid` = 0 and other fields 0.
- Consume:
  - At posedge with `stall` = 0, advance past all emitted instructions.
  - Entries fully emitted are popped; a partially emitted entry updates `head_word`.
  - A newly exposed head entry starts at its `start_word`.
- Squash (`rob_if_packet.squash` = 1):
  - At posedge, clear every queue entry and set `fetch_pc` to `rob_if_packet.PC`.
  - No request is issued in the squash cycle.
  - All outputs are forced invalid in the squash cycle.
  - Squash has priority over response capture, consume, and push in the same cycle.

## Timing
- Reset values: queue empty, `fetch_pc` = 0, `proc2Imem_command` = MEM_NONE, `proc2Imem_addr` = 0, all `if_id_packet.valid` = 0.
- Reset overrides squash and memory activity.
- The request and the grant occur in the same cycle; the tag is valid before the posedge.
- Data captured at posedge k is visible on `if_id_packet` in cycle k+1.
- Simultaneous capture of an entry's data and push of a new entry in one cycle must both succeed.
- Queue full: no request is issued until the next pop.
- Wrap-around: queue pointers wrap modulo 4. Full and empty are distinguished by an occupancy count.
- `stall` = 1 holds `if_id_packet` stable, except for newly arrived later data filling empty slots. The oldest slots never change.

## Configuration
- `IF_MULTI_REQ_EN`: when defined, up to `FETCH_Q_DEPTH` requests may be outstanding.
- When not defined, a new request is issued only when no queue entry is waiting for data. Output and squash behaviour are identical.

## Structure
- In the shared sys_defs package:
  - Types MEM_TAG, MEM_BLOCK, MEM_COMMAND, ADDR, INST, ROB_IF_PACKET, IF_ID_PACKET.
  - Constants `N` and `FETCH_Q_DEPTH`.
- Natural sub-module: `fetch_req_queue`, the tagged in-order queue with push, tag-match capture, pop count, and flush.

## Test plan
- Reset held, then released, with memory all zero:
  - First request is MEM_LOAD at 0x0.
  - Once data arrives, slot 0 has PC 0x0 and slot 1 has PC 0x4, both valid with inst 0.
- Block 0x100 preloaded with {0x00500113, 0x00100093}, squash to 0x100 → first outputs are inst 0x00100093 at PC 0x100, then 0x00500113 at PC 0x104.
- Squash to 0x104 → request to 0x100; the first valid output is PC 0x104; the low word is never emitted.
- Memory returns tag 0 for the request → the same address is re-requested next cycle; `fetch_pc` is unchanged.
- `stall` = 1 for 5 cycles with data available → `if_id_packet` holds the same PCs; after release, the sequence continues without loss or duplication.
- Squash while two requests are outstanding → their late responses are dropped; only target-path instructions appear; the first new request is to the aligned target.

Source files
------------

// File: rtl/sys_defs_pkg.sv
// Shared core definitions: memory interface types, fetch/decode packets,
// fetch width N and fetch request queue sizing.
package sys_defs_pkg;

    localparam int unsigned N             = 2;
    localparam int unsigned FETCH_Q_DEPTH = 4;
    localparam int unsigned FQ_IDX_W      = 2;   // log2(FETCH_Q_DEPTH)
    localparam int unsigned FQ_CNT_W      = 3;   // holds 0..FETCH_Q_DEPTH

    typedef logic [3:0]  MEM_TAG;
    typedef logic [63:0] MEM_BLOCK;
    typedef logic [31:0] ADDR;
    typedef logic [31:0] INST;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'h0,
        MEM_LOAD  = 2'h1,
        MEM_STORE = 2'h2
    } MEM_COMMAND;

    typedef struct packed {
        logic squash;
        ADDR  PC;
    } ROB_IF_PACKET;

    typedef struct packed {
        INST  inst;
        ADDR  PC;
        ADDR  NPC;
        logic valid;
    } IF_ID_PACKET;

    // Fetch queue entry as stored
    typedef struct packed {
        logic     valid;
        MEM_TAG   tag;
        ADDR      blk_addr;
        logic     start_word;
        logic     data_valid;
        MEM_BLOCK data;
    } fq_entry_t;

    // Fetch queue entry as seen by the emit logic
    typedef struct packed {
        ADDR      blk_addr;
        logic     start_word;
        logic     data_valid;
        MEM_BLOCK data;
    } fq_view_t;

    // Select word 0 (low) or word 1 (high) of a fetched block
    function automatic INST blk_word(input MEM_BLOCK d, input logic w);
        return w ? d[63:32] : d[31:0];
    endfunction

endpackage

// File: rtl/fetch_req_queue.sv
// Tagged in-order queue of outstanding/completed fetch block requests.
// Ports:
//   clock, reset        : clock, synchronous active-high reset
//   flush               : clear every entry (redirect)
//   push/push_*         : append a granted request at the tail
//   rsp_tag/rsp_data    : returned block; tag 0 = nothing returned
//   pop_cnt             : number of head entries retired this cycle
//   view[i]             : entry at head+i, oldest first
//   count, full         : occupancy
module fetch_req_queue
    import sys_defs_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic                push,
    input  MEM_TAG              push_tag,
    input  ADDR                 push_addr,
    input  logic                push_start,
    input  MEM_TAG              rsp_tag,
    input  MEM_BLOCK            rsp_data,
    input  logic [FQ_CNT_W-1:0] pop_cnt,
    output fq_view_t            view [FETCH_Q_DEPTH],
    output logic [FQ_CNT_W-1:0] count,
    output logic                full
);

    fq_entry_t           q [FETCH_Q_DEPTH];
    logic [FQ_IDX_W-1:0] head;
    logic [FQ_IDX_W-1:0] tail;

    // Capture, pop and push touch disjoint entries: capture only hits
    // waiting entries, pop only retires completed ones, push fills a free slot.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            for (int i = 0; i < FETCH_Q_DEPTH; i++) q[i] <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < FETCH_Q_DEPTH; i++) begin
                if (q[i].valid && !q[i].data_valid && (rsp_tag != '0) && (q[i].tag == rsp_tag)) begin
                    q[i].data_valid <= 1'b1;
                    q[i].data       <= rsp_data;
                end
            end
            for (int k = 0; k < FETCH_Q_DEPTH; k++) begin
                if (FQ_CNT_W'(k) < pop_cnt) q[head + FQ_IDX_W'(k)].valid <= 1'b0;
            end
            if (push) begin
                q[tail] <= '{valid: 1'b1, tag: push_tag, blk_addr: push_addr,
                             start_word: push_start, data_valid: 1'b0, data: '0};
            end
            head  <= head + FQ_IDX_W'(pop_cnt);
            tail  <= tail + FQ_IDX_W'(push);
            count <= count - pop_cnt + FQ_CNT_W'(push);
        end
    end

    // Rotated view so the consumer always sees the oldest entry at index 0
    always_comb begin
        for (int i = 0; i < FETCH_Q_DEPTH; i++) begin
            view[i].blk_addr   = q[head + FQ_IDX_W'(i)].blk_addr;
            view[i].start_word = q[head + FQ_IDX_W'(i)].start_word;
            view[i].data_valid = q[head + FQ_IDX_W'(i)].data_valid;
            view[i].data       = q[head + FQ_IDX_W'(i)].data;
        end
    end

    assign full = (count == FQ_CNT_W'(FETCH_Q_DEPTH));

endmodule

// File: rtl/stage_fetch.sv
// N-wide instruction fetch stage. Issues tagged 64-bit block loads, tracks
// them in fetch_req_queue and presents up to N program-ordered instructions
// per cycle to decode; a ROB squash flushes everything and restarts at PC.
// Optional: IF_MULTI_REQ_EN allows up to FETCH_Q_DEPTH loads in flight;
// otherwise a new load waits until no queued block is still waiting for data.
// Ports:
//   clock, reset              : clock, synchronous active-high reset
//   stall                     : decode not accepting this cycle
//   mem2proc_transaction_tag  : tag granted to this cycle's request (0 = reject)
//   mem2proc_data/_data_tag   : returned block and its tag (0 = none)
//   rob_if_packet             : squash + redirect PC
//   proc2Imem_command/_addr   : block load request (combinational)
//   if_id_packet[N]           : instructions to decode, slot 0 oldest (combinational)
module stage_fetch
    import sys_defs_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   stall,
    input  MEM_TAG                 mem2proc_transaction_tag,
    input  MEM_BLOCK               mem2proc_data,
    input  MEM_TAG                 mem2proc_data_tag,
    input  ROB_IF_PACKET           rob_if_packet,
    output MEM_COMMAND             proc2Imem_command,
    output ADDR                    proc2Imem_addr,
    output IF_ID_PACKET [N-1:0]    if_id_packet
);

    localparam ADDR BLK_MASK = ~ADDR'(7);

    ADDR                 fetch_pc;
    logic                head_word;
    fq_view_t            view [FETCH_Q_DEPTH];
    logic [FQ_CNT_W-1:0] count;
    logic                full;
    logic                req_gate;
    logic                req;
    logic                push;
    ADDR                 blk_addr;
    logic [FQ_CNT_W-1:0] walk_ent;
    logic                walk_word;
    logic [FQ_CNT_W-1:0] pop_cnt;
    logic [FQ_CNT_W-1:0] remain;

`ifdef IF_MULTI_REQ_EN
    assign req_gate = 1'b1;
`else
    // Single outstanding load: hold off while any queued block awaits data
    always_comb begin
        req_gate = 1'b1;
        for (int i = 0; i < FETCH_Q_DEPTH; i++) begin
            if ((FQ_CNT_W'(i) < count) && !view[i].data_valid) req_gate = 1'b0;
        end
    end
`endif

    assign blk_addr          = fetch_pc & BLK_MASK;
    assign req               = !full && !rob_if_packet.squash && !reset && req_gate;
    assign push              = req && (mem2proc_transaction_tag != '0);
    assign proc2Imem_command = req ? MEM_LOAD : MEM_NONE;
    assign proc2Imem_addr    = req ? blk_addr : '0;

    fetch_req_queue u_queue (
        .clock      (clock),
        .reset      (reset),
        .flush      (rob_if_packet.squash),
        .push       (push),
        .push_tag   (mem2proc_transaction_tag),
        .push_addr  (blk_addr),
        .push_start (fetch_pc[2]),
        .rsp_tag    (mem2proc_data_tag),
        .rsp_data   (mem2proc_data),
        .pop_cnt    (pop_cnt),
        .view       (view),
        .count      (count),
        .full       (full)
    );

    // Walk from the head entry/word filling slots until data runs out;
    // walk_ent/walk_word end at the first unemitted instruction.
    always_comb begin
        logic [FQ_CNT_W-1:0] r;
        logic                w;
        logic                stop;
        if_id_packet = '0;
        r    = '0;
        w    = head_word;
        stop = 1'b0;
        for (int s = 0; s < N; s++) begin
            if (!stop && (r < count) && view[r[FQ_IDX_W-1:0]].data_valid) begin
                if_id_packet[s].inst  = blk_word(view[r[FQ_IDX_W-1:0]].data, w);
                if_id_packet[s].PC    = view[r[FQ_IDX_W-1:0]].blk_addr + ADDR'({w, 2'b00});
                if_id_packet[s].NPC   = view[r[FQ_IDX_W-1:0]].blk_addr + ADDR'({w, 2'b00}) + ADDR'(4);
                if_id_packet[s].valid = 1'b1;
                if (w) begin
                    r = r + FQ_CNT_W'(1);
                    w = view[r[FQ_IDX_W-1:0]].start_word;
                end else begin
                    w = 1'b1;
                end
            end else begin
                stop = 1'b1;
            end
        end
        walk_ent  = r;
        walk_word = w;
        if (reset || rob_if_packet.squash) if_id_packet = '0;
    end

    assign pop_cnt = (stall || reset || rob_if_packet.squash) ? '0 : walk_ent;
    assign remain  = count - pop_cnt;

    // Next word of the head entry; a block pushed into an empty queue
    // becomes the head and starts at its own start_word.
    always_ff @(posedge clock) begin
        if (reset || rob_if_packet.squash) begin
            head_word <= 1'b0;
        end else begin
            if (!stall) head_word <= (walk_ent == count) ? 1'b0 : walk_word;
            if ((remain == '0) && push) head_word <= fetch_pc[2];
        end
    end

    // Next block to request; a rejected grant retries the same block
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= '0;
        end else if (rob_if_packet.squash) begin
            fetch_pc <= rob_if_packet.PC;
        end else if (push) begin
            fetch_pc <= blk_addr + ADDR'(8);
        end
    end

endmodule

// File: tb/tb_stage_fetch.sv
// Randomized self-checking bench for stage_fetch. A memory model grants and
// returns tagged blocks with random latency/rejection; a reference model of
// the expected instruction stream checks requests and decode slots each cycle.
module tb_stage_fetch;
    import sys_defs_pkg::*;

    logic               clock = 1'b0;
    logic               reset;
    logic               stall;
    MEM_TAG             gnt_tag;
    MEM_BLOCK           rsp_data;
    MEM_TAG             rsp_tag;
    ROB_IF_PACKET       rob;
    MEM_COMMAND         cmd;
    ADDR                maddr;
    IF_ID_PACKET [N-1:0] pkt;

    always #5 clock = ~clock;

    stage_fetch dut (
        .clock                    (clock),
        .reset                    (reset),
        .stall                    (stall),
        .mem2proc_transaction_tag (gnt_tag),
        .mem2proc_data            (rsp_data),
        .mem2proc_data_tag        (rsp_tag),
        .rob_if_packet            (rob),
        .proc2Imem_command        (cmd),
        .proc2Imem_addr           (maddr),
        .if_id_packet             (pkt)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory image: zero below 0x100, directed block at 0x100, hash above
    function automatic INST mem_word(input ADDR a);
        if (a == 32'h100) return 32'h0010_0093;
        if (a == 32'h104) return 32'h0050_0113;
        if (a < 32'h100)  return '0;
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    // Memory side: outstanding tags
    bit  busy      [16];
    ADDR busy_addr [16];
    int  busy_due  [16];
    int  cyc = 0;

    // Reference: live fetched blocks in program order and stream position
    typedef struct {
        ADDR    addr;
        MEM_TAG tag;
        bit     has_data;
    } blk_t;
    blk_t live[$];
    ADDR  exp_pc   = '0;
    ADDR  next_req = '0;
    int   consumed = 0;

    task automatic step(input bit do_rst, input bit do_stall, input bit do_sq,
                        input ADDR tgt, input int rej_pct, input int lat_max);
        int     cand[$];
        int     free_t[$];
        int     rt;
        int     exp_n;
        bit     exp_req;
        bit     wait_data;
        MEM_TAG gnt;
        ADDR    pc;

        reset      = do_rst;
        stall      = do_stall;
        rob.squash = do_sq;
        rob.PC     = tgt;
        rsp_tag    = '0;
        rsp_data   = '0;
        gnt_tag    = '0;
        rt         = 0;
        for (int t = 1; t < 16; t++) if (busy[t] && busy_due[t] <= cyc) cand.push_back(t);
        if (cand.size() != 0 && $urandom_range(0, 3) != 0) begin
            rt       = cand[$urandom_range(0, cand.size() - 1)];
            rsp_tag  = MEM_TAG'(rt);
            rsp_data = {mem_word(busy_addr[rt] + 32'd4), mem_word(busy_addr[rt])};
        end
        #1;

        wait_data = 1'b0;
        foreach (live[i]) if (!live[i].has_data) wait_data = 1'b1;
`ifdef IF_MULTI_REQ_EN
        wait_data = 1'b0;
`endif
        exp_req = !do_rst && !do_sq && (live.size() < FETCH_Q_DEPTH) && !wait_data;
        check_eq("req_cmd", 64'(cmd), 64'(exp_req ? MEM_LOAD : MEM_NONE));
        check_eq("req_addr", 64'(maddr), exp_req ? 64'(next_req) : 64'd0);

        gnt = '0;
        if (cmd == MEM_LOAD && $urandom_range(1, 100) > rej_pct) begin
            for (int t = 1; t < 16; t++) if (!busy[t] && t != rt) free_t.push_back(t);
            if (free_t.size() != 0) gnt = MEM_TAG'(free_t[$urandom_range(0, free_t.size() - 1)]);
        end
        gnt_tag = gnt;
        if (gnt != '0) begin
            busy[gnt]      = 1'b1;
            busy_addr[gnt] = maddr;
            busy_due[gnt]  = cyc + int'($urandom_range(1, lat_max));
        end
        if (rt != 0) busy[rt] = 1'b0;
        #1;

        // Words available from exp_pc through consecutive completed blocks
        exp_n = 0;
        if (!do_rst && !do_sq) begin
            foreach (live[i]) begin
                if (!live[i].has_data) break;
                exp_n += (i == 0 && exp_pc[2]) ? 1 : 2;
            end
            if (exp_n > N) exp_n = N;
        end
        for (int s = 0; s < N; s++) begin
            pc = exp_pc + ADDR'(4 * s);
            check_eq($sformatf("slot%0d_valid", s), 64'(pkt[s].valid), 64'(s < exp_n));
            if (s < exp_n) begin
                check_eq($sformatf("slot%0d_pc", s), 64'(pkt[s].PC), 64'(pc));
                check_eq($sformatf("slot%0d_inst", s), 64'(pkt[s].inst), 64'(mem_word(pc)));
                check_eq($sformatf("slot%0d_npc", s), 64'(pkt[s].NPC), 64'(pc + 32'd4));
            end else begin
                check_eq($sformatf("slot%0d_idle", s),
                         64'(pkt[s].inst | pkt[s].PC | pkt[s].NPC), 64'd0);
            end
        end

        // Advance the reference to the state after this clock edge
        if (do_rst) begin
            live.delete();
            exp_pc   = '0;
            next_req = '0;
        end else if (do_sq) begin
            live.delete();
            exp_pc   = tgt;
            next_req = {tgt[31:3], 3'b000};
        end else begin
            if (rt != 0) foreach (live[i]) if (live[i].tag == MEM_TAG'(rt) && !live[i].has_data) live[i].has_data = 1'b1;
            if (!do_stall) begin
                for (int k = 0; k < exp_n; k++) begin
                    pc     = exp_pc;
                    exp_pc = exp_pc + 32'd4;
                    consumed++;
                    if (pc[2]) void'(live.pop_front());
                end
            end
            if (exp_req && gnt != '0) begin
                live.push_back('{addr: next_req, tag: gnt, has_data: 1'b0});
                next_req = next_req + 32'd8;
            end
        end

        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    initial begin
        reset   = 1'b1;
        stall   = 1'b0;
        gnt_tag = '0;
        rsp_tag = '0;
        rsp_data = '0;
        rob     = '0;
        @(negedge clock);

        // Reset, then fetch from 0 with zero memory
        repeat (3)  step(1, 0, 0, '0, 0, 3);
        repeat (20) step(0, 0, 0, '0, 0, 3);
        // Directed block at 0x100, aligned and mid-block targets
        step(0, 0, 1, 32'h100, 0, 3);
        repeat (15) step(0, 0, 0, '0, 0, 3);
        step(0, 0, 1, 32'h104, 0, 3);
        repeat (10) step(0, 0, 0, '0, 0, 3);
        // Rejected grants retry the same block
        repeat (3)  step(0, 0, 0, '0, 100, 3);
        repeat (6)  step(0, 0, 0, '0, 0, 3);
        // Stall with data available
        repeat (5)  step(0, 1, 0, '0, 0, 2);
        repeat (10) step(0, 0, 0, '0, 0, 2);
        // Squash with slow loads in flight; late responses must be dropped
        repeat (4)  step(0, 0, 0, '0, 0, 12);
        step(0, 0, 1, 32'h20C, 0, 3);
        repeat (30) step(0, 0, 0, '0, 0, 3);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 499) == 0,
                 $urandom_range(0, 9) < 3,
                 $urandom_range(0, 49) == 0,
                 32'h200 + ADDR'($urandom_range(0, 255) << 2),
                 15, int'($urandom_range(1, 8)));
        end

        check_eq("progress", 64'(consumed > 200), 64'd1);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
